// File: rtl/video_pattern_timing_gen.sv
// Programmable video timing generator with built-in RGB test patterns, 1 or 2 pixels per clock.
// Pattern and solid colour are shadowed at the frame boundary so a frame is never torn mid-way.
module video_pattern_timing_gen #(
  parameter int    H_ACTIVE       = 160,
  parameter int    H_FP           = 8,
  parameter int    H_SYNC         = 16,
  parameter int    H_BP           = 24,
  parameter int    V_ACTIVE       = 120,
  parameter int    V_FP           = 2,
  parameter int    V_SYNC         = 2,
  parameter int    V_BP           = 4,
  parameter string HSYNC_POL      = "NEGATIVE",
  parameter string VSYNC_POL      = "NEGATIVE",
  parameter int    PIXELS_PER_CLK = 1,
  parameter int    FCNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              link_i,
  input  logic              repeat_en,
  input  logic [1:0]        pattern_sel,
  input  logic [23:0]       solid_rgb,
  output logic              vsync,
  output logic              hsync,
  output logic              data_valid,
  output logic [7:0]        data0_r,
  output logic [7:0]        data0_g,
  output logic [7:0]        data0_b,
  output logic [7:0]        data1_r,
  output logic [7:0]        data1_g,
  output logic [7:0]        data1_b,
  output logic              sof,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int PPC     = PIXELS_PER_CLK;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int HT      = H_TOTAL / PPC;
  localparam int VT      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(HT + 1);
  localparam int VW      = $clog2(VT + 1);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BPW     = $clog2(BAR_W + PPC + 1);

  localparam logic HS_ON = (HSYNC_POL == "POSITIVE") ? 1'b1 : 1'b0;
  localparam logic VS_ON = (VSYNC_POL == "POSITIVE") ? 1'b1 : 1'b0;

  localparam logic [HW-1:0]  H_LAST    = HW'(HT - 1);
  localparam logic [HW-1:0]  H_ACT_END = HW'(H_ACTIVE / PPC);
  localparam logic [HW-1:0]  HS_BEG    = HW'((H_ACTIVE + H_FP) / PPC);
  localparam logic [HW-1:0]  HS_END    = HW'((H_ACTIVE + H_FP + H_SYNC) / PPC);
  localparam logic [VW-1:0]  V_LAST    = VW'(VT - 1);
  localparam logic [VW-1:0]  V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BPW-1:0] BAR_LEN   = BPW'(BAR_W);
  localparam logic [BPW-1:0] BAR_STEP  = BPW'(PPC);
  localparam logic [BPW-1:0] BAR_ONE   = BPW'(1);

  if ((PPC != 1 && PPC != 2) || (H_ACTIVE % PPC) != 0 || (H_FP % PPC) != 0 ||
      (H_SYNC % PPC) != 0 || (H_BP % PPC) != 0 || H_ACTIVE < 16) begin : g_bad_cfg
    $error("video_pattern_timing_gen: illegal PIXELS_PER_CLK / horizontal timing combination");
  end

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [HW-1:0]      h_q, h_d;
  logic [VW-1:0]      v_q, v_d;
  logic               first_q, first_d;
  logic [1:0]         pat_q, pat_d;
  logic [23:0]        solid_q, solid_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [3:0]         bar_idx_q, bar_idx_d;
  logic [BPW-1:0]     bar_pos_q, bar_pos_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic               dv_q, dv_d, sof_q, sof_d;
  logic [23:0]        rgb0_q, rgb0_d, rgb1_q, rgb1_d;

  logic [BPW-1:0]     bar_sum_s;
  logic [3:0]         bar_idx1_s;
  logic [7:0]         x0_s, x1_s;
  logic               y4_s;

  function automatic logic [3:0] bar_inc(input logic [3:0] idx);
    bar_inc = (idx == 4'd8) ? idx : idx + 4'd1;
  endfunction

  function automatic logic [23:0] bar_rgb(input logic [3:0] idx);
    case (idx)
      4'd0:    bar_rgb = 24'hFFFFFF;
      4'd1:    bar_rgb = 24'hFFFF00;
      4'd2:    bar_rgb = 24'h00FFFF;
      4'd3:    bar_rgb = 24'h00FF00;
      4'd4:    bar_rgb = 24'hFF00FF;
      4'd5:    bar_rgb = 24'hFF0000;
      4'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] pattern_rgb(input logic [1:0] pat, input logic [7:0] x,
                                              input logic y4, input logic [3:0] idx,
                                              input logic [23:0] solid);
    case (pat)
      2'd0:    pattern_rgb = bar_rgb(idx);
      2'd1:    pattern_rgb = {x, x, x};
      2'd2:    pattern_rgb = (x[4] ^ y4) ? 24'hFFFFFF : 24'h000000;
      2'd3:    pattern_rgb = solid;
      default: pattern_rgb = 24'h000000;
    endcase
  endfunction

  assign x0_s       = (PPC == 2) ? 8'({h_q, 1'b0}) : 8'(h_q);
  assign x1_s       = x0_s + 8'd1;
  assign y4_s       = |(v_q & VW'(16));
  assign bar_sum_s  = bar_pos_q + BAR_STEP;
  assign bar_idx1_s = (bar_pos_q + BAR_ONE == BAR_LEN) ? bar_inc(bar_idx_q) : bar_idx_q;

  // Raster counters, run/idle FSM, frame counter and frame-boundary shadow registers
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    first_d = first_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        h_d = HW'(0);
        v_d = VW'(0);
        if (link_i) begin
          state_d = ST_RUN;
          if (first_q) begin
            pat_d   = pattern_sel;
            solid_d = solid_rgb;
            first_d = 1'b0;
          end else begin
            pat_d   = pat_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (h_q == H_LAST) begin
          h_d = HW'(0);
          if (v_q == V_LAST) begin
            v_d     = VW'(0);
            fcnt_d  = fcnt_q + FCNT_W'(1);
            pat_d   = repeat_en ? pattern_sel : pat_q + 2'd1;
            solid_d = solid_rgb;
            state_d = link_i ? ST_RUN : ST_IDLE;
          end else begin
            v_d = v_q + VW'(1);
          end
        end else begin
          h_d = h_q + HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Running colour-bar position, restarted at every line start; index 8 saturates as black
  always_comb begin
    bar_idx_d = bar_idx_q;
    bar_pos_d = bar_pos_q;
    if (state_q != ST_RUN || h_q == H_LAST) begin
      bar_idx_d = 4'd0;
      bar_pos_d = BPW'(0);
    end else if (bar_sum_s >= BAR_LEN) begin
      bar_idx_d = bar_inc(bar_idx_q);
      bar_pos_d = bar_sum_s - BAR_LEN;
    end else begin
      bar_idx_d = bar_idx_q;
      bar_pos_d = bar_sum_s;
    end
  end

  // Sync/enable decode and pixel colour, registered one clock after the counter state
  always_comb begin
    hsync_d = ~HS_ON;
    vsync_d = ~VS_ON;
    dv_d    = 1'b0;
    sof_d   = 1'b0;
    rgb0_d  = 24'h000000;
    rgb1_d  = 24'h000000;
    if (state_q == ST_RUN) begin
      hsync_d = (h_q >= HS_BEG && h_q < HS_END) ? HS_ON : ~HS_ON;
      vsync_d = (v_q >= VS_BEG && v_q < VS_END) ? VS_ON : ~VS_ON;
      dv_d    = (h_q < H_ACT_END) && (v_q < V_ACT_END);
      sof_d   = (h_q == HW'(0)) && (v_q == VW'(0));
      if (dv_d) begin
        rgb0_d = pattern_rgb(pat_q, x0_s, y4_s, bar_idx_q, solid_q);
        rgb1_d = (PPC == 2) ? pattern_rgb(pat_q, x1_s, y4_s, bar_idx1_s, solid_q) : 24'h000000;
      end else begin
        rgb0_d = 24'h000000;
        rgb1_d = 24'h000000;
      end
    end else begin
      hsync_d = ~HS_ON;
      vsync_d = ~VS_ON;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      h_q       <= HW'(0);
      v_q       <= VW'(0);
      first_q   <= 1'b1;
      pat_q     <= 2'd0;
      solid_q   <= 24'h000000;
      fcnt_q    <= FCNT_W'(0);
      bar_idx_q <= 4'd0;
      bar_pos_q <= BPW'(0);
      hsync_q   <= ~HS_ON;
      vsync_q   <= ~VS_ON;
      dv_q      <= 1'b0;
      sof_q     <= 1'b0;
      rgb0_q    <= 24'h000000;
      rgb1_q    <= 24'h000000;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      first_q   <= first_d;
      pat_q     <= pat_d;
      solid_q   <= solid_d;
      fcnt_q    <= fcnt_d;
      bar_idx_q <= bar_idx_d;
      bar_pos_q <= bar_pos_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      dv_q      <= dv_d;
      sof_q     <= sof_d;
      rgb0_q    <= rgb0_d;
      rgb1_q    <= rgb1_d;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign data_valid = dv_q;
  assign sof        = sof_q;
  assign frame_cnt  = fcnt_q;
  assign {data0_r, data0_g, data0_b} = rgb0_q;
  assign {data1_r, data1_g, data1_b} = rgb1_q;

endmodule
